// File: rtl/spi_fl_cmd_seq.sv
// spi_fl_cmd_seq: turns single user requests (read / program / sector erase) into the
// sequence of SPI-flash sub-commands a byte-level flash controller understands.
//
//   read    : READ(0x03) -> response with the read word
//   program : WREN(0x06) -> PP(0x02) -> RDSR(0x05) until WIP clears -> response
//   erase   : WREN(0x06) -> SE(0x20) -> RDSR(0x05) until WIP clears -> response
//   op 11   : reserved, answered immediately with an error response
//
// Ports
//   clk, rst                 single clock, synchronous active-high reset
//   req_valid/op/addr/wdata  user request, accepted when req_valid & req_ready
//   req_ready                idle and the controller is ready
//   rsp_valid/rdata/err      one-cycle completion pulse; rdata is the read word or the
//                            last status byte zero-extended; err flags timeout/reserved op
//   fl_*  (outputs)          command fields and one-cycle issue strobe fl_validflag
//   fl_tready                controller ready (drops while a sub-command is running)
//   fl_dataout/validflag_out data returned by the controller
module spi_fl_cmd_seq #(
  parameter logic [15:0] POLL_MAX = 16'd65535,
  parameter int unsigned ADDR_W   = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [7:0]        fl_command,
  output logic [ADDR_W-1:0] fl_address,
  output logic [31:0]       fl_datain,
  output logic [6:0]        fl_ndata_bits,
  output logic [3:0]        fl_dummy_cycles,
  output logic [9:0]        fl_frame_struct,
  output logic [2:0]        fl_commtype,
  output logic              fl_validflag,
  input  logic              fl_tready,
  input  logic [31:0]       fl_dataout,
  input  logic              fl_validflag_out
);

  localparam logic [1:0] OpRead  = 2'b00;
  localparam logic [1:0] OpProg  = 2'b01;
  localparam logic [1:0] OpErase = 2'b10;

  localparam logic [2:0] CtCmd       = 3'd0;
  localparam logic [2:0] CtCmdRd     = 3'd1;
  localparam logic [2:0] CtCmdAddrWr = 3'd2;
  localparam logic [2:0] CtCmdAddr   = 3'd3;
  localparam logic [2:0] CtCmdAddrRd = 3'd4;

  localparam logic [7:0] CmdWren  = 8'h06;
  localparam logic [7:0] CmdRead  = 8'h03;
  localparam logic [7:0] CmdProg  = 8'h02;
  localparam logic [7:0] CmdErase = 8'h20;
  localparam logic [7:0] CmdRdsr  = 8'h05;

  typedef enum logic [2:0] {
    StIdle, StWrenI, StWrenW, StOpI, StOpW, StPollI, StPollW, StResp
  } state_e;

  state_e state_q, state_d;

  // Latched request
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  // Command field registers
  logic [7:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] fl_addr_q, fl_addr_d;
  logic [31:0]       datain_q, datain_d;
  logic [6:0]        ndata_q, ndata_d;
  logic [2:0]        commtype_q, commtype_d;
  logic              validflag_q, validflag_d;

  // Sub-command tracking and captured data
  logic              seen_busy_q, seen_busy_d;
  logic [15:0]       poll_cnt_q, poll_cnt_d;
  logic [7:0]        status_q, status_d;
  logic [31:0]       read_q, read_d;

  // Response registers
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;

  logic              accept;
  logic              in_wait;
  logic              sub_done;
  logic [7:0]        status_eff;
  logic [31:0]       read_eff;
  logic [1:0]        op_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic [31:0]       wdata_sel;

  // Held low during reset so nothing is accepted before rst deasserts.
  assign req_ready = (state_q == StIdle) && fl_tready && !rst;
  assign accept    = req_valid && req_ready;

  assign in_wait  = (state_q == StWrenW) || (state_q == StOpW) || (state_q == StPollW);
  // A sub-command is finished only once the controller has visibly gone busy and come back.
  assign sub_done = in_wait && fl_tready && seen_busy_q;

  // Data arriving in the completion cycle itself must still be used.
  assign status_eff = fl_validflag_out ? fl_dataout[7:0] : status_q;
  assign read_eff   = fl_validflag_out ? fl_dataout : read_q;

  // In the acceptance cycle the request fields are not latched yet.
  assign op_sel    = (state_q == StIdle) ? req_op    : op_q;
  assign addr_sel  = (state_q == StIdle) ? req_addr  : addr_q;
  assign wdata_sel = (state_q == StIdle) ? req_wdata : wdata_q;

  // State register and all datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= 2'b00;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      cmd_q       <= 8'h0;
      fl_addr_q   <= '0;
      datain_q    <= 32'h0;
      ndata_q     <= 7'd0;
      commtype_q  <= 3'd0;
      validflag_q <= 1'b0;
      seen_busy_q <= 1'b0;
      poll_cnt_q  <= 16'd0;
      status_q    <= 8'h0;
      read_q      <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cmd_q       <= cmd_d;
      fl_addr_q   <= fl_addr_d;
      datain_q    <= datain_d;
      ndata_q     <= ndata_d;
      commtype_q  <= commtype_d;
      validflag_q <= validflag_d;
      seen_busy_q <= seen_busy_d;
      poll_cnt_q  <= poll_cnt_d;
      status_q    <= status_d;
      read_q      <= read_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          unique case (req_op)
            OpRead:          state_d = StOpI;
            OpProg, OpErase: state_d = StWrenI;
            default:         state_d = StResp;
          endcase
        end
      end
      StWrenI: state_d = StWrenW;
      StWrenW: if (sub_done) state_d = StOpI;
      StOpI:   state_d = StOpW;
      StOpW: begin
        if (sub_done) state_d = (op_q == OpRead) ? StResp : StPollI;
      end
      StPollI: state_d = StPollW;
      StPollW: begin
        if (sub_done) begin
          if (status_eff[0] && (poll_cnt_q < POLL_MAX)) state_d = StPollI;
          else                                          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cmd_d       = cmd_q;
    fl_addr_d   = fl_addr_q;
    datain_d    = datain_q;
    ndata_d     = ndata_q;
    commtype_d  = commtype_q;
    seen_busy_d = seen_busy_q;
    poll_cnt_d  = poll_cnt_q;
    status_d    = status_q;
    read_d      = read_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;

    if (accept) begin
      op_d    = req_op;
      addr_d  = req_addr;
      wdata_d = req_wdata;
    end

    // Fields are loaded on entry to an issue state and held until the next issue.
    unique case (state_d)
      StWrenI: begin
        cmd_d      = CmdWren;
        commtype_d = CtCmd;
        ndata_d    = 7'd0;
        fl_addr_d  = '0;
        datain_d   = 32'h0;
      end
      StOpI: begin
        fl_addr_d = addr_sel;
        datain_d  = 32'h0;
        unique case (op_sel)
          OpRead: begin
            cmd_d      = CmdRead;
            commtype_d = CtCmdAddrRd;
            ndata_d    = 7'd32;
          end
          OpProg: begin
            cmd_d      = CmdProg;
            commtype_d = CtCmdAddrWr;
            ndata_d    = 7'd32;
            datain_d   = wdata_sel;
          end
          default: begin
            cmd_d      = CmdErase;
            commtype_d = CtCmdAddr;
            ndata_d    = 7'd0;
          end
        endcase
      end
      StPollI: begin
        cmd_d      = CmdRdsr;
        commtype_d = CtCmdRd;
        ndata_d    = 7'd8;
        fl_addr_d  = '0;
        datain_d   = 32'h0;
      end
      default: ;
    endcase

    validflag_d = (state_d == StWrenI) || (state_d == StOpI) || (state_d == StPollI);

    if (validflag_d)                seen_busy_d = 1'b0;
    else if (in_wait && !fl_tready) seen_busy_d = 1'b1;

    // Returned data is only meaningful while waiting on the matching sub-command.
    if ((state_q == StOpW) && (op_q == OpRead) && fl_validflag_out) read_d   = fl_dataout;
    if ((state_q == StPollW) && fl_validflag_out)                   status_d = fl_dataout[7:0];

    // Counter never exceeds POLL_MAX, so it cannot wrap.
    if (accept) begin
      poll_cnt_d = 16'd0;
    end else if ((state_q == StPollW) && sub_done && status_eff[0] &&
                 (poll_cnt_q < POLL_MAX)) begin
      poll_cnt_d = poll_cnt_q + 16'd1;
    end

    rsp_valid_d = (state_d == StResp);
    if (state_d == StResp) begin
      unique case (state_q)
        StIdle: begin  // reserved op
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 32'h0;
        end
        StOpW: begin
          rsp_err_d   = 1'b0;
          rsp_rdata_d = read_eff;
        end
        default: begin  // poll finished: WIP still set means the poll budget ran out
          rsp_err_d   = status_eff[0];
          rsp_rdata_d = {24'h0, status_eff};
        end
      endcase
    end
  end

  assign rsp_valid       = rsp_valid_q;
  assign rsp_err         = rsp_err_q;
  assign rsp_rdata       = rsp_rdata_q;
  assign fl_command      = cmd_q;
  assign fl_address      = fl_addr_q;
  assign fl_datain       = datain_q;
  assign fl_ndata_bits   = ndata_q;
  assign fl_commtype     = commtype_q;
  assign fl_validflag    = validflag_q;
  assign fl_dummy_cycles = 4'd0;
  assign fl_frame_struct = 10'd0;

endmodule

// File: doc/spi_fl_cmd_seq.md
SPI_FL_CMD_SEQ -- requirements
Module: spi_fl_cmd_seq

Interface
REQ-001 SHALL have parameter POLL_MAX, default 16'd65535: maximum status-register polls before timeout.
REQ-002 SHALL have parameter ADDR_W, default 24: flash address width.
REQ-003 SHALL have port clk  in  1: single clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1: reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  in  1: user request strobe.
REQ-006 SHALL have port req_op  in  2: operation; 00 read, 01 program, 10 sector erase, 11 reserved.
REQ-007 SHALL have port req_addr  in  ADDR_W: flash byte address.
REQ-008 SHALL have port req_wdata  in  32: program data.
REQ-009 SHALL have port req_ready  out  1: sequencer accepts a request this cycle.
REQ-010 SHALL have port rsp_valid  out  1: one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata  out  32: read data, or the last status byte zero-extended.
REQ-012 SHALL have port rsp_err  out  1: timeout or reserved op; valid with rsp_valid.
REQ-013 SHALL have flash-controller ports:
- fl_command  out  8
- fl_address  out  ADDR_W
- fl_datain  out  32
- fl_ndata_bits  out  7
- fl_dummy_cycles  out  4
- fl_frame_struct  out  10
- fl_commtype  out  3
- fl_validflag  out  1
- fl_tready  in  1
- fl_dataout  in  32
- fl_validflag_out  in  1

Function
REQ-014 SHALL drive fl_dummy_cycles=0 and fl_frame_struct=0 (single lane) at all times.
REQ-015 SHALL use these commtype codes: 0 command only; 1 command+read; 2 command+address+write; 3 command+address; 4 command+address+read.
REQ-016 SHALL implement states IDLE, WREN_I, WREN_W, OP_I, OP_W, POLL_I, POLL_W, RESP.
REQ-017 SHALL assert req_ready only in IDLE with fl_tready=1; a request is accepted when req_valid&req_ready, and op/addr/wdata are latched that cycle.
REQ-018 SHALL transition from IDLE on acceptance: read to OP_I; program or erase to WREN_I; reserved op to RESP with err=1.
REQ-019 SHALL, in each *_I state, pulse fl_validflag for exactly one cycle, with command fields stable from that cycle until the matching *_W state exits, then go to *_W.
REQ-020 SHALL treat a sub-command as complete in a *_W state on the first cycle with fl_tready=1 after fl_tready has been seen 0 since the issue pulse.
REQ-021 SHALL issue WREN as command 0x06, commtype 0, ndata_bits 0; on completion go to OP_I.
REQ-022 SHALL issue OP read as 0x03, commtype 4, ndata_bits 32, address=latched addr; capture fl_dataout when fl_validflag_out=1; on completion go to RESP.
REQ-023 SHALL issue OP program as 0x02, commtype 2, ndata_bits 32, fl_datain=latched wdata; on completion go to POLL_I.
REQ-024 SHALL issue OP erase as 0x20, commtype 3, ndata_bits 0; on completion go to POLL_I.
REQ-025 SHALL issue POLL as 0x05, commtype 1, ndata_bits 8; on completion, evaluate the status byte captured from fl_dataout[7:0] on fl_validflag_out.
REQ-026 SHALL handle the POLL result:
- WIP (status bit0)=0: go to RESP, err=0.
- WIP=1 and poll count<POLL_MAX: increment count, go to POLL_I.
- WIP=1 and count==POLL_MAX: go to RESP, err=1.
REQ-027 SHALL clear the poll counter on acceptance; the counter is 16 bits, saturating, never wraps.
REQ-028 SHALL, in RESP, assert rsp_valid for one cycle with rsp_rdata/rsp_err valid, then return to IDLE.
REQ-029 SHALL hold rsp_rdata until the next RESP.
REQ-030 SHALL ignore req_valid outside of acceptance cycles; no queuing.
REQ-031 SHALL ignore a fl_validflag_out pulse outside OP_W (read) or POLL_W.
REQ-032 SHALL treat fl_tready=0 in IDLE as busy: req_ready stays 0.

Reset
REQ-033 SHALL, on rst=1 at a clock edge, enter IDLE.
REQ-034 SHALL reset fl_validflag, req_ready, rsp_valid, rsp_err, rsp_rdata, fl_command, fl_address, fl_datain, fl_ndata_bits, fl_commtype and the poll counter to 0.
REQ-035 SHALL abort any in-flight sequence on reset mid-operation with no rsp_valid; the first request is accepted no earlier than the cycle after rst deasserts.

Verification
REQ-036 SHALL cover read: req_op=00, addr=0x012340 -> one validflag pulse with cmd 0x03, commtype 4, ndata 32; controller returns 0xDEADBEEF -> rsp_valid, rdata=0xDEADBEEF, err=0.
REQ-037 SHALL cover program: op=01, addr=0x000100, wdata=0xA5A5A5A5, status returns 0x03,0x03,0x00 -> command order 0x06, 0x02, 0x05 x3; rsp err=0, rdata=0x00.
REQ-038 SHALL cover erase timeout: POLL_MAX=3, status always 0x01 -> commands 0x06, 0x20, then 4 polls; rsp err=1, rdata=0x01.
REQ-039 SHALL cover a reserved op: op=11 -> no validflag; rsp_valid the cycle after RESP entry with err=1.
REQ-040 SHALL cover reset mid-POLL_W: rst=1 for one cycle -> all outputs 0, no rsp_valid; a new read request then completes normally.
REQ-041 SHALL cover back-pressure: fl_tready=0 in IDLE with req_valid=1 -> req_ready=0, no acceptance until fl_tready=1.
